// File: rtl/local_port_injector.sv
// local_port_injector
// Network-interface transmitter feeding a router's local input port. It takes
// packet requests (destination + payload-flit count) and a payload word stream
// from the core, claims a free downstream VC and serializes each packet into
// HEAD/BODY/TAIL (or a single HEADTAIL) flit, honouring per-VC on/off flow
// control and the router's VC-allocatable status.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   pkt_valid_i/ready_o   packet request handshake
//   x_dest_i, y_dest_i    destination coordinates carried in the head flit
//   pkt_len_i             payload flit count, 0..MAX_PKT_LEN
//   pld_valid_i/data_i    payload word from the core
//   pld_ready_o           payload word consumed this cycle
//   data_o, valid_o       registered flit towards the router
//   on_off_i              per-VC on/off back-pressure
//   allocatable_i         per-VC idle indication
//   error_o               one-cycle pulse on an oversized request
//
// Build option: define LPI_RR_VC_SEL_EN for round-robin VC selection; without
// it the lowest free VC index always wins.

package noc_params;
  localparam int VC_NUM           = 4;
  localparam int VC_SIZE          = $clog2(VC_NUM);
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int FLIT_DATA_SIZE   = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t                 flit_label;
    logic [VC_SIZE-1:0]          vc_id;
    logic [FLIT_DATA_SIZE-1:0]   data;
  } flit_t;
endpackage

module local_port_injector #(
  parameter int MAX_PKT_LEN = 8,
  parameter int LW          = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      pkt_valid_i,
  output logic                                      pkt_ready_o,
  input  logic [noc_params::DEST_ADDR_SIZE_X-1:0]   x_dest_i,
  input  logic [noc_params::DEST_ADDR_SIZE_Y-1:0]   y_dest_i,
  input  logic [LW-1:0]                             pkt_len_i,
  input  logic                                      pld_valid_i,
  input  logic [noc_params::FLIT_DATA_SIZE-1:0]     pld_data_i,
  output logic                                      pld_ready_o,
  output noc_params::flit_t                         data_o,
  output logic                                      valid_o,
  input  logic [noc_params::VC_NUM-1:0]             on_off_i,
  input  logic [noc_params::VC_NUM-1:0]             allocatable_i,
  output logic                                      error_o
);

  localparam int VCN  = noc_params::VC_NUM;
  localparam int VCW  = noc_params::VC_SIZE;
  localparam int XW   = noc_params::DEST_ADDR_SIZE_X;
  localparam int YW   = noc_params::DEST_ADDR_SIZE_Y;
  localparam int DW   = noc_params::FLIT_DATA_SIZE;
  localparam int PADW = DW - XW - YW;

  typedef enum logic [1:0] {IDLE, VC_SEL, HEAD, PAYLOAD} state_t;

  state_t            state, state_next;
  logic [VCW-1:0]    cur_vc, cur_vc_next;
  logic [XW-1:0]     x_dest, x_dest_next;
  logic [YW-1:0]     y_dest, y_dest_next;
  logic [LW-1:0]     len, len_next;
  logic [LW-1:0]     remaining, remaining_next;
  logic [VCN-1:0]    hold_mask, hold_set;
  logic [VCN-1:0]    candidates;
  logic              cand_found;
  logic [VCW-1:0]    cand_idx;
  logic              send;
  logic              error_next;
  noc_params::flit_t flit_next;
`ifdef LPI_RR_VC_SEL_EN
  logic [VCW-1:0]    rr_ptr, rr_ptr_next;
`endif

  // A VC whose head we just sent stays masked until the router shows it busy.
  assign candidates  = allocatable_i & ~hold_mask;
  assign pkt_ready_o = (state == IDLE);
  assign pld_ready_o = (state == PAYLOAD) && on_off_i[cur_vc] && pld_valid_i;

  // VC picker: first candidate found scanning from the search start.
  always_comb begin
    int idx;
    cand_found = 1'b0;
    cand_idx   = '0;
    idx        = 0;
    for (int i = 0; i < VCN; i++) begin
`ifdef LPI_RR_VC_SEL_EN
      idx = (int'(rr_ptr) + i) % VCN;
`else
      idx = i;
`endif
      if (!cand_found && candidates[idx[VCW-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = idx[VCW-1:0];
      end else begin
        cand_found = cand_found;
      end
    end
  end

  // Next-state, flit build and handshake decode.
  always_comb begin
    state_next     = state;
    cur_vc_next    = cur_vc;
    x_dest_next    = x_dest;
    y_dest_next    = y_dest;
    len_next       = len;
    remaining_next = remaining;
    hold_set       = '0;
    send           = 1'b0;
    error_next     = 1'b0;
    flit_next      = '0;
    flit_next.vc_id = cur_vc;
`ifdef LPI_RR_VC_SEL_EN
    rr_ptr_next    = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (pkt_valid_i) begin
          // Oversized requests are swallowed with an error pulse.
          if (pkt_len_i > LW'(MAX_PKT_LEN)) begin
            error_next = 1'b1;
          end else begin
            x_dest_next = x_dest_i;
            y_dest_next = y_dest_i;
            len_next    = pkt_len_i;
            state_next  = VC_SEL;
          end
        end else begin
          state_next = IDLE;
        end
      end
      VC_SEL: begin
        if (cand_found) begin
          cur_vc_next = cand_idx;
          state_next  = HEAD;
`ifdef LPI_RR_VC_SEL_EN
          rr_ptr_next = (int'(cand_idx) == VCN - 1) ? '0 : cand_idx + VCW'(1);
`endif
        end else begin
          state_next = VC_SEL;
        end
      end
      HEAD: begin
        if (on_off_i[cur_vc]) begin
          send             = 1'b1;
          hold_set[cur_vc] = 1'b1;
          flit_next.data   = {x_dest, y_dest, {PADW{1'b0}}};
          if (len == LW'(0)) begin
            flit_next.flit_label = noc_params::HEADTAIL;
            state_next           = IDLE;
          end else begin
            flit_next.flit_label = noc_params::HEAD;
            remaining_next       = len;
            state_next           = PAYLOAD;
          end
        end else begin
          state_next = HEAD;
        end
      end
      PAYLOAD: begin
        if (on_off_i[cur_vc] && pld_valid_i) begin
          send           = 1'b1;
          flit_next.data = pld_data_i;
          remaining_next = remaining - LW'(1);
          if (remaining == LW'(1)) begin
            flit_next.flit_label = noc_params::TAIL;
            state_next           = IDLE;
          end else begin
            flit_next.flit_label = noc_params::BODY;
            state_next           = PAYLOAD;
          end
        end else begin
          state_next = PAYLOAD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; on hold_mask a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_vc    <= '0;
      x_dest    <= '0;
      y_dest    <= '0;
      len       <= '0;
      remaining <= '0;
      hold_mask <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      error_o   <= 1'b0;
`ifdef LPI_RR_VC_SEL_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state     <= state_next;
      cur_vc    <= cur_vc_next;
      x_dest    <= x_dest_next;
      y_dest    <= y_dest_next;
      len       <= len_next;
      remaining <= remaining_next;
      hold_mask <= (hold_mask & allocatable_i) | hold_set;
      valid_o   <= send;
      error_o   <= error_next;
      if (send) begin
        data_o <= flit_next;
      end
`ifdef LPI_RR_VC_SEL_EN
      rr_ptr    <= rr_ptr_next;
`endif
    end
  end

endmodule
